add_share_sequencer: RTL and testbench
======================================

Name: add_share_sequencer

Overview:
- Time-shares one external 4-bit full adder (A, B, C_in -> S, C_out) among NUM_REQ requesters, e.g. the band-pass filter tap accumulators.
- Performs 4*NIBBLES-bit additions serially, one nibble per cycle, least-significant nibble first, with a registered ripple carry between nibbles.
- Arbitration between requesters is round-robin.
- Each result is returned on a valid/ready result port tagged with the requester index.

Parameters:
- NUM_REQ, 2: number of requesters (>=2).
- NIBBLES, 4: nibbles per operand; operand width OW = 4*NIBBLES.
- ID_W, 1: width of requester index; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_ready  out  NUM_REQ  per-requester accept strobe.
- req_a  in  NUM_REQ*OW  operand A; requester i occupies bits [i*OW +: OW].
- req_b  in  NUM_REQ*OW  operand B; same packing as req_a.
- req_cin  in  NUM_REQ  carry-in per requester.
- add_a  out  4  nibble to adder input A.
- add_b  out  4  nibble to adder input B.
- add_cin  out  1  carry to adder input C_in.
- add_s  in  4  adder sum; combinational return from the adder.
- add_cout  in  1  adder carry-out.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_sum  out  OW  full sum.
- res_cout  out  1  final carry-out.
- res_id  out  ID_W  index of the requester that issued this result.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (synchronous, any state, including mid-RUN or DONE):
  - state=IDLE, rr_ptr=0, nib=0, carry=0.
  - res_valid=0, res_sum=0, res_cout=0, res_id=0.
  - req_ready=0, add_a=add_b=0, add_cin=0.
  - Any in-flight operation is dropped; no result is emitted.
- IDLE:
  - grant = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[grant]=1 combinationally in this cycle; all other req_ready bits stay 0. req_ready is never 1 outside IDLE.
  - On the accepting edge, latch a, b, cin and id=grant; set nib=0, carry=cin; go to RUN.
  - If no req_valid is set, stay in IDLE.
- RUN, cycle k (k = 0..NIBBLES-1):
  - Drive add_a=a[4k+3:4k], add_b=b[4k+3:4k], add_cin=carry.
  - At the clock edge, capture add_s into sum[4k+3:4k] and load carry<=add_cout.
  - After the k=NIBBLES-1 edge: res_cout<=add_cout, go to DONE.
  - Outside RUN, add_a, add_b and add_cin are driven to 0.
- DONE:
  - res_valid=1; res_sum, res_cout and res_id are stable.
  - When res_ready=1: transfer occurs, res_valid drops next cycle, rr_ptr<=(id+1) mod NUM_REQ, go to IDLE.
  - If res_ready=0, hold indefinitely; new requests are not accepted (backpressure).
- Latency: accept at edge T, RUN occupies the NIBBLES cycles following T, res_valid is high in the next cycle. Minimum issue interval is NIBBLES+2 cycles.
- Arithmetic: {res_cout, res_sum} = a + b + cin, modulo 2**(OW+1). Overflow wraps; res_cout carries bit OW.
- Requester protocol: a requester holds req_valid and its operands stable until it sees req_ready. Operand changes after acceptance do not affect the operation in progress.
- Simultaneous requests: exactly one grant per accept cycle. rr_ptr advances only when a result transfers, so a persistently requesting client cannot starve the others.

Test Plan:
1. Single requester: req0 a=0x1234, b=0x0F0F, cin=0, res_ready=1. Response: res_sum=0x2143, res_cout=0, res_id=0. res_valid rises exactly NIBBLES+1 cycles after the accept cycle.
2. Carry ripple and wrap: a=0xFFFF, b=0x0001, cin=0 gives 0x0000 with cout=1. Then a=0xFFFF, b=0x0000, cin=1 also gives 0x0000 with cout=1. Carry must propagate through all 4 nibbles.
3. Round-robin: both requesters held valid for 4 operations; expected res_id sequence is 0,1,0,1. Also check req_ready is one-hot, one cycle wide, and only asserted in IDLE.
4. Backpressure: hold res_ready=0 for 10 cycles in DONE. res_valid and res_sum must remain stable, and req_ready must stay 0 throughout. Release res_ready; the next grant goes to the other requester.
5. Reset mid-RUN: assert reset during the nibble-2 cycle. The next cycle shows all outputs at reset values and no result is emitted. A subsequent request 0x0001+0x0001 yields 0x0002 with res_id=0.
6. Operand change after accept: alter req_a during RUN. The result reflects the latched operands; golden model is a+b+cin checked against 200 random operand pairs.

Source files
------------

// File: rtl/add_share_sequencer.sv
// rtl/add_share_sequencer.sv - round-robin sequencer sharing one external 4-bit adder
// Operands are added one nibble per cycle, LSB nibble first, with a registered ripple carry.
module add_share_sequencer #(
    parameter  int NUM_REQ = 2,
    parameter  int NIBBLES = 4,
    parameter  int ID_W    = 1,
    localparam int OW      = 4 * NIBBLES
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*OW-1:0] req_a,
    input  logic [NUM_REQ*OW-1:0] req_b,
    input  logic [NUM_REQ-1:0]    req_cin,
    output logic [3:0]            add_a,
    output logic [3:0]            add_b,
    output logic                  add_cin,
    input  logic [3:0]            add_s,
    input  logic                  add_cout,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [OW-1:0]         res_sum,
    output logic                  res_cout,
    output logic [ID_W-1:0]       res_id
);

    localparam int NIB_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [NIB_W-1:0] LAST_NIB  = NIB_W'(NIBBLES - 1);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]    NUM_REQ_X = (ID_W + 1)'(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [NIB_W-1:0]    r_nib;
    logic                r_carry;
    logic [OW-1:0]       r_a;
    logic [OW-1:0]       r_b;
    logic [OW-1:0]       r_sum;
    logic                r_cout;
    logic [ID_W-1:0]     r_id;

    logic [2*NUM_REQ-1:0] w_req_dbl;
    logic [2*NUM_REQ-1:0] w_req_rot;
    logic                 w_found;
    logic [ID_W:0]        w_cand;
    logic [ID_W-1:0]      w_grant;
    logic [OW-1:0]        w_sel_a;
    logic [OW-1:0]        w_sel_b;
    logic                 w_sel_cin;
    logic                 w_accept;
    logic                 w_last_nib;
    logic [OW+3:0]        w_sum_cat;
    logic [ID_W-1:0]      w_next_ptr;

    // Rotate the request vector so bit 0 corresponds to the current round-robin pointer.
    assign w_req_dbl = {req_valid, req_valid};
    assign w_req_rot = w_req_dbl >> r_rr_ptr;

    always_comb begin
        w_found = 1'b0;
        w_cand  = '0;
        w_grant = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (w_req_rot[j]) begin
                w_found = 1'b1;
                w_cand  = {1'b0, r_rr_ptr} + (ID_W + 1)'(j);
                w_grant = (w_cand >= NUM_REQ_X) ? ID_W'(w_cand - NUM_REQ_X) : w_cand[ID_W-1:0];
            end
        end
    end

    assign w_accept   = (r_state == IDLE) && w_found;
    assign w_last_nib = (r_nib == LAST_NIB);
    assign w_sum_cat  = {add_s, r_sum};
    assign w_next_ptr = (r_id == LAST_ID) ? '0 : r_id + 1'b1;

    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_cin = 1'b0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant == ID_W'(i)) begin
                w_sel_a      = req_a[i*OW +: OW];
                w_sel_b      = req_b[i*OW +: OW];
                w_sel_cin    = req_cin[i];
                req_ready[i] = w_accept && !reset;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_found)    w_next_state = RUN;
            RUN:     if (w_last_nib) w_next_state = DONE;
            DONE:    if (res_ready)  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operands shift right each RUN cycle so the active nibble is always at [3:0];
    // the sum shifts in from the top so it lands aligned after the last nibble.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr <= '0;
            r_nib    <= '0;
            r_carry  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_id     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_carry <= w_sel_cin;
                        r_id    <= w_grant;
                        r_nib   <= '0;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> 4;
                    r_b     <= r_b >> 4;
                    r_sum   <= w_sum_cat[OW+3:4];
                    r_carry <= add_cout;
                    r_nib   <= r_nib + 1'b1;
                    if (w_last_nib) begin
                        r_cout <= add_cout;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                default: ;
            endcase
        end
    end

    assign add_a     = ((r_state == RUN) && !reset) ? r_a[3:0] : 4'h0;
    assign add_b     = ((r_state == RUN) && !reset) ? r_b[3:0] : 4'h0;
    assign add_cin   = ((r_state == RUN) && !reset) ? r_carry  : 1'b0;
    assign res_valid = (r_state == DONE);
    assign res_sum   = r_sum;
    assign res_cout  = r_cout;
    assign res_id    = r_id;

endmodule

// File: tb/tb_add_share_sequencer.sv
// tb/tb_add_share_sequencer.sv - directed self-checking bench for add_share_sequencer
module tb_add_share_sequencer;

    localparam int NIBBLES = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [1:0]  req_cin;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_cin;
    logic [3:0]  add_s;
    logic        add_cout;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_sum;
    logic        res_cout;
    logic [0:0]  res_id;

    int n_cmp = 0;
    int n_err = 0;

    add_share_sequencer #(
        .NUM_REQ(2),
        .NIBBLES(NIBBLES),
        .ID_W(1)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_cin  (req_cin),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_sum  (res_sum),
        .res_cout (res_cout),
        .res_id   (res_id)
    );

    // External 4-bit full adder
    assign {add_cout, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic [15:0] a, input logic [15:0] b, input logic cin);
        if (idx == 0) begin
            req_a[15:0] = a;
            req_b[15:0] = b;
            req_cin[0]  = cin;
        end else begin
            req_a[31:16] = a;
            req_b[31:16] = b;
            req_cin[1]   = cin;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    task automatic do_op(input int idx, input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic [15:0] exp_sum, input logic exp_cout, input logic scramble);
        int         cyc;
        int         lat;
        logic [4:0] n0;
        set_req(idx, a, b, cin);
        req_valid = (idx == 0) ? 2'b01 : 2'b10;
        res_ready = 1'b1;
        #1;
        cyc = 0;
        while (!req_ready[idx] && cyc < 30) begin
            @(negedge clock); #1; cyc++;
        end
        chk("accept_ready", 64'(req_ready[idx]), 64'(1'b1));
        lat = 0;
        do begin
            @(negedge clock); #1; lat++;
            if (lat == 1) begin
                req_valid = '0;
                if (scramble) begin
                    req_a = {16'($urandom), 16'($urandom)};
                    req_b = {16'($urandom), 16'($urandom)};
                    req_cin = 2'($urandom);
                end
                #1;
                chk("nib0_add_a", 64'(add_a), 64'(a[3:0]));
                chk("nib0_add_b", 64'(add_b), 64'(b[3:0]));
                chk("nib0_add_cin", 64'(add_cin), 64'(cin));
            end else if (lat == 2) begin
                n0 = 5'(a[3:0]) + 5'(b[3:0]) + 5'(cin);
                chk("nib1_add_cin", 64'(add_cin), 64'(n0[4]));
            end
        end while (!res_valid && lat < 30);
        chk("latency", 64'(lat), 64'(NIBBLES + 1));
        chk("res_sum", 64'(res_sum), 64'(exp_sum));
        chk("res_cout", 64'(res_cout), 64'(exp_cout));
        chk("res_id", 64'(res_id), 64'(idx));
        @(negedge clock); #1;
        chk("res_valid_drop", 64'(res_valid), 64'(1'b0));
    endtask

    initial begin
        int          cyc;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [16:0] rexp;

        // Reset state, with requests pending to show reset blocks acceptance
        reset     = 1'b1;
        req_valid = 2'b11;
        req_a     = 32'h5555_AAAA;
        req_b     = 32'h1234_4321;
        req_cin   = 2'b11;
        res_ready = 1'b1;
        @(negedge clock);
        @(negedge clock); #1;
        chk("rst_res_valid", 64'(res_valid), 64'(1'b0));
        chk("rst_res_sum", 64'(res_sum), 64'(16'h0000));
        chk("rst_res_cout", 64'(res_cout), 64'(1'b0));
        chk("rst_res_id", 64'(res_id), 64'(1'b0));
        chk("rst_req_ready", 64'(req_ready), 64'(2'b00));
        chk("rst_add_a", 64'(add_a), 64'(4'h0));
        chk("rst_add_cin", 64'(add_cin), 64'(1'b0));
        req_valid = 2'b00;
        reset     = 1'b0;
        @(negedge clock); #1;

        // Single requester
        do_op(0, 16'h1234, 16'h0F0F, 1'b0, 16'h2143, 1'b0, 1'b0);

        // Carry ripple through every nibble and wrap
        do_op(0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op(1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Round-robin with both requesters held valid
        do_reset();
        set_req(0, 16'h1111, 16'h2222, 1'b0);
        set_req(1, 16'h8000, 16'h8001, 1'b1);
        req_valid = 2'b11;
        res_ready = 1'b1;
        #1;
        for (int op_i = 0; op_i < 4; op_i++) begin
            cyc = 0;
            while (req_ready == 2'b00 && cyc < 30) begin
                @(negedge clock); #1; cyc++;
            end
            chk("rr_onehot", 64'($onehot(req_ready)), 64'(1));
            chk("rr_grant", 64'(req_ready), (op_i % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
            chk("rr_ready_idle", 64'(res_valid), 64'(1'b0));
            cyc = 0;
            do begin
                @(negedge clock); #1; cyc++;
                if (cyc == 1) chk("rr_ready_width", 64'(req_ready), 64'(2'b00));
            end while (!res_valid && cyc < 30);
            chk("rr_id", 64'(res_id), 64'(op_i % 2));
            chk("rr_sum", 64'(res_sum), (op_i % 2 == 0) ? 64'(16'h3333) : 64'(16'h0002));
            chk("rr_cout", 64'(res_cout), (op_i % 2 == 0) ? 64'(1'b0) : 64'(1'b1));
        end
        req_valid = 2'b00;
        @(negedge clock); #1;

        // Backpressure in DONE, then the other requester gets the next grant
        do_reset();
        req_valid = 2'b11;
        res_ready = 1'b0;
        #1;
        cyc = 0;
        while (req_ready == 2'b00 && cyc < 30) begin
            @(negedge clock); #1; cyc++;
        end
        chk("bp_first_grant", 64'(req_ready), 64'(2'b01));
        cyc = 0;
        do begin
            @(negedge clock); #1; cyc++;
        end while (!res_valid && cyc < 30);
        chk("bp_sum", 64'(res_sum), 64'(16'h3333));
        for (int k = 0; k < 10; k++) begin
            @(negedge clock); #1;
            chk("bp_hold_valid", 64'(res_valid), 64'(1'b1));
            chk("bp_hold_sum", 64'(res_sum), 64'(16'h3333));
            chk("bp_hold_ready", 64'(req_ready), 64'(2'b00));
        end
        res_ready = 1'b1;
        @(negedge clock); #1;
        chk("bp_next_grant", 64'(req_ready), 64'(2'b10));
        cyc = 0;
        do begin
            @(negedge clock); #1; cyc++;
            if (cyc == 1) req_valid = 2'b00;
        end while (!res_valid && cyc < 30);
        chk("bp_next_id", 64'(res_id), 64'(1'b1));
        chk("bp_next_sum", 64'(res_sum), 64'(16'h0002));
        @(negedge clock); #1;

        // Reset during the nibble-2 cycle drops the operation
        set_req(1, 16'hABCD, 16'h1234, 1'b1);
        req_valid = 2'b10;
        #1;
        cyc = 0;
        while (!req_ready[1] && cyc < 30) begin
            @(negedge clock); #1; cyc++;
        end
        chk("mid_accept", 64'(req_ready[1]), 64'(1'b1));
        @(negedge clock);
        req_valid = 2'b00;
        @(negedge clock);
        @(negedge clock); #1;
        chk("mid_nib2_add_a", 64'(add_a), 64'(4'hB));
        chk("mid_nib2_add_b", 64'(add_b), 64'(4'h2));
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mid_res_valid", 64'(res_valid), 64'(1'b0));
        chk("mid_res_sum", 64'(res_sum), 64'(16'h0000));
        chk("mid_res_cout", 64'(res_cout), 64'(1'b0));
        chk("mid_res_id", 64'(res_id), 64'(1'b0));
        chk("mid_req_ready", 64'(req_ready), 64'(2'b00));
        chk("mid_add_a", 64'(add_a), 64'(4'h0));
        chk("mid_add_b", 64'(add_b), 64'(4'h0));
        chk("mid_add_cin", 64'(add_cin), 64'(1'b0));
        for (int k = 0; k < 8; k++) begin
            @(negedge clock); #1;
            chk("mid_no_result", 64'(res_valid), 64'(1'b0));
        end
        do_op(0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        // Random operands, request lines scrambled after acceptance
        for (int i = 0; i < 200; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rc   = 1'($urandom);
            rexp = 17'(ra) + 17'(rb) + 17'(rc);
            do_op(i % 2, ra, rb, rc, rexp[15:0], rexp[16], 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
